// File: rtl/rgb_stream_pkg.sv
// Shared types and constants for the RGB stream path (arbiter, converter, DMA glue).
// A beat carries four 32-bit 0BGR888 pixels.
package rgb_stream_pkg;

    localparam int unsigned PIX_PER_BEAT = 4;
    localparam int unsigned BEAT_W       = 128;
    localparam int unsigned KEEP_W       = BEAT_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // One-hot owner view of the arbiter state: 01=s0, 10=s1, 00=none.
    function automatic logic [1:0] state_to_grant(arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        if (st == GRANT0) g = 2'b01;
        if (st == GRANT1) g = 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry AXI-Stream register slice with a registered input ready.
// Full throughput when the sink is always ready; output held stable while stalled.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;
    logic             pop;

    always_comb begin
        push         = in_valid_i & in_ready_q;
        pop          = main_valid_q & out_ready_i;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (pop || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = push;
                if (push) skid_data_d = in_data_i;
            end else begin
                main_valid_d = push;
                if (push) main_data_d = in_data_i;
            end
        end else if (push) begin
            // Output stalled: park the new beat in the second entry.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end

        in_ready_d = !(main_valid_d && skid_valid_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/rgb_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one RGB888->RGB565 converter between two
// DMA read streams, with a registered skid output and per-source packet statistics.
module rgb_stream_arbiter #(
    parameter int unsigned DATA_W        = 128,
    parameter int unsigned KEEP_W        = 16,
    parameter int unsigned MAX_PKT_BEATS = 1024,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              s0_tvalid,
    output logic              s0_tready,
    input  logic              s0_tlast,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic              s1_tvalid,
    output logic              s1_tready,
    input  logic              s1_tlast,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic [DATA_W-1:0] s1_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [DATA_W-1:0] m_tdata,
    output logic [1:0]        grant,
    input  logic              clear_stats,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic              overrun_err
);

    import rgb_stream_pkg::*;

    localparam int unsigned BCNT_W = $clog2(MAX_PKT_BEATS + 1);
    localparam int unsigned SKID_W = DATA_W + KEEP_W + 1;
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(MAX_PKT_BEATS - 1);

    arb_state_t        state_q, state_d;
    logic              rr_last_q, rr_last_d;  // 1 = s1 was served last
    logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0]  pkt_cnt1_q, pkt_cnt1_d;
    logic              overrun_q, overrun_d;

    logic              src_valid;
    logic              src_last;
    logic [KEEP_W-1:0] src_keep;
    logic [DATA_W-1:0] src_data;
    logic              skid_in_ready;
    logic              limit_hit;
    logic              beat_acc;
    logic [SKID_W-1:0] skid_in_data;
    logic [SKID_W-1:0] skid_out_data;

    always_comb begin
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_keep  = '0;
        src_data  = '0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        unique case (state_q)
            GRANT0: begin
                src_valid = s0_tvalid;
                src_last  = s0_tlast;
                src_keep  = s0_tkeep;
                src_data  = s0_tdata;
                s0_tready = skid_in_ready;
            end
            GRANT1: begin
                src_valid = s1_tvalid;
                src_last  = s1_tlast;
                src_keep  = s1_tkeep;
                src_data  = s1_tdata;
                s1_tready = skid_in_ready;
            end
            default: ;
        endcase
    end

    // This beat is the MAX_PKT_BEATS-th of the grant: it closes the packet regardless.
    assign limit_hit    = (beat_cnt_q == LAST_IDX);
    assign beat_acc     = src_valid & skid_in_ready;
    assign skid_in_data = {src_last | limit_hit, src_keep, src_data};

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (s0_tvalid && (!s1_tvalid || rr_last_q)) begin
                    state_d = GRANT0;
                end else if (s1_tvalid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (beat_acc) begin
                    if (src_last || limit_hit) begin
                        state_d    = IDLE;
                        rr_last_d  = (state_q == GRANT1);
                        beat_cnt_d = '0;
                        if (state_q == GRANT0) pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
                        else                   pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
                        if (!src_last) overrun_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_stats) begin
            pkt_cnt0_d = '0;
            pkt_cnt1_d = '0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            beat_cnt_q <= '0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
            overrun_q  <= overrun_d;
        end
    end

    axis_skid_buffer #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk_i      (aclk),
        .rst_i      (areset),
        .in_valid_i (src_valid),
        .in_ready_o (skid_in_ready),
        .in_data_i  (skid_in_data),
        .out_valid_o(m_tvalid),
        .out_ready_i(m_tready),
        .out_data_o (skid_out_data)
    );

    assign {m_tlast, m_tkeep, m_tdata} = skid_out_data;
    assign grant       = state_to_grant(state_q);
    assign pkt_cnt0    = pkt_cnt0_q;
    assign pkt_cnt1    = pkt_cnt1_q;
    assign overrun_err = overrun_q;

endmodule
